gbc_mbc3_rtc: RTL and testbench

Wishbone target implementing the MBC3 real-time clock that the Game Boy Color mapper drives through its RTC initiator port. It keeps a live seconds/minutes/hours/day counter advanced from the system clock, exposes the MBC3 latch-and-read register model, and accepts writes that set the clock. The mapper forwards $A000-$BFFF accesses here when RAMBankID selects $08-$0C, and forwards MBC3 latch writes ($6000-$7FFF) here as well.

---
 rtl/gbc_rtc_pkg.sv | 49 ++++
 rtl/gbc_rtc_counter.sv | 69 ++++++
 rtl/gbc_mbc3_rtc.sv | 128 ++++++++++++
 tb/tb_gbc_mbc3_rtc.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gbc_rtc_pkg.sv
// Shared types for the MBC3 real-time clock: register indices, field widths,
// the live/latched time record and the 48-bit save image layout.
package gbc_rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 9;
    localparam int TIME_W = 2 + DAY_W + HOUR_W + MIN_W + SEC_W;
    localparam int SAVE_W = 48;

    typedef enum logic [3:0] {
        RtcLatch = 4'h0,
        RtcSec   = 4'h8,
        RtcMin   = 4'h9,
        RtcHour  = 4'hA,
        RtcDayLo = 4'hB,
        RtcDayHi = 4'hC
    } rtc_reg_e;

    typedef struct packed {
        logic              day_carry;
        logic              halt;
        logic [DAY_W-1:0]  day;
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } rtc_time_t;

    // The upper bits stand in for the prescaler state and are always zero.
    typedef struct packed {
        logic [SAVE_W-TIME_W-1:0] pad;
        rtc_time_t                t;
    } save_image_t;

    // Returns {carry, next}; out-of-range values count up to 63 and wrap silently.
    function automatic logic [6:0] inc60(input logic [5:0] v);
        if (v == 6'd59)      return {1'b1, 6'd0};
        else if (v == 6'd63) return {1'b0, 6'd0};
        else                 return {1'b0, v + 6'd1};
    endfunction

    function automatic logic [5:0] inc24(input logic [4:0] v);
        if (v == 5'd23)      return {1'b1, 5'd0};
        else if (v == 5'd31) return {1'b0, 5'd0};
        else                 return {1'b0, v + 5'd1};
    endfunction

endpackage

// File: rtl/gbc_rtc_counter.sv
// Live MBC3 clock fields with cascaded tick/carry; a write to a field replaces
// it and blocks any carry into or through it. Restore overrides everything.
module gbc_rtc_counter
    import gbc_rtc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      tick,
    input  logic [4:0] wr_field,
    input  logic [7:0] wr_data,
    input  logic      restore,
    input  rtc_time_t restore_time,
    output rtc_time_t live
);

    rtc_time_t nxt;
    logic      c;

    always_comb begin
        nxt = live;
        c   = tick;

        if (wr_field[0]) begin
            nxt.sec = wr_data[5:0];
            c       = 1'b0;
        end else if (c) begin
            {c, nxt.sec} = inc60(live.sec);
        end

        if (wr_field[1]) begin
            nxt.min = wr_data[5:0];
            c       = 1'b0;
        end else if (c) begin
            {c, nxt.min} = inc60(live.min);
        end

        if (wr_field[2]) begin
            nxt.hour = wr_data[4:0];
            c        = 1'b0;
        end else if (c) begin
            {c, nxt.hour} = inc24(live.hour);
        end

        // Day is split across two registers; either write claims the whole field.
        if (wr_field[3] || wr_field[4]) begin
            if (wr_field[3]) nxt.day[7:0] = wr_data;
            if (wr_field[4]) begin
                nxt.day[8]    = wr_data[0];
                nxt.halt      = wr_data[6];
                nxt.day_carry = wr_data[7];
            end
        end else if (c) begin
            if (live.day == 9'd511) begin
                nxt.day       = '0;
                nxt.day_carry = 1'b1;
            end else begin
                nxt.day = live.day + 9'd1;
            end
        end

        if (restore) nxt = restore_time;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) live <= '0;
        else     live <= nxt;
    end

endmodule

// File: rtl/gbc_mbc3_rtc.sv
// Wishbone target for the MBC3 RTC: prescaler, latch port, latched register set
// and single-cycle response. GBC_RTC_SAVE_EN adds the save/restore image ports.
module gbc_mbc3_rtc
    import gbc_rtc_pkg::*;
#(
    parameter int CLK_HZ = 33554432
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic [7:0]  dat_to_target,
    output logic [7:0]  dat_to_initiator,
    input  logic        we,
    input  logic        cyc,
    input  logic        stb,
    output logic        ack,
    output logic        stall
`ifdef GBC_RTC_SAVE_EN
    ,
    output logic [47:0] save_image,
    input  logic [47:0] restore_image,
    input  logic        restore_strobe
`endif
);

    localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    // Valid/ready: a request is taken on every cycle with cyc && stb (never
    // stalled) and answered by ack, with read data, on the following cycle only.
    logic          req;
    logic          wr;
    logic [4:0]    wr_field;
    logic [PW-1:0] presc;
    logic          tick;
    logic          restore;
    rtc_time_t     restore_time;
    rtc_time_t     live;
    rtc_time_t     lat;
    logic          arm;
    logic [7:0]    rd_val;

    assign req   = cyc && stb;
    assign wr    = req && we;
    assign stall = 1'b0;

    assign wr_field = {wr && (addr == RtcDayHi), wr && (addr == RtcDayLo),
                       wr && (addr == RtcHour),  wr && (addr == RtcMin),
                       wr && (addr == RtcSec)};

`ifdef GBC_RTC_SAVE_EN
    logic unused_restore_hi;
    assign unused_restore_hi = ^restore_image[47:TIME_W];
    assign restore           = restore_strobe;
    assign restore_time      = restore_image[TIME_W-1:0];
    assign save_image        = {{(SAVE_W-TIME_W){1'b0}}, live};
`else
    assign restore      = 1'b0;
    assign restore_time = '0;
`endif

    assign tick = !live.halt && (presc == PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          presc <= '0;
        else if (restore || wr_field[0])  presc <= '0;
        else if (!live.halt)              presc <= tick ? '0 : presc + 1'b1;
    end

    gbc_rtc_counter u_counter (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .wr_field    (wr_field),
        .wr_data     (dat_to_target),
        .restore     (restore),
        .restore_time(restore_time),
        .live        (live)
    );

    // The latch copies the registered (pre-tick) live values on a 0->1 arm edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat <= '0;
            arm <= 1'b0;
        end else begin
            if (wr && (addr == RtcLatch)) begin
                arm <= dat_to_target[0];
                if (dat_to_target[0] && !arm) lat <= live;
            end
            if (!restore) begin
                if (wr_field[0]) lat.sec         <= dat_to_target[5:0];
                if (wr_field[1]) lat.min         <= dat_to_target[5:0];
                if (wr_field[2]) lat.hour        <= dat_to_target[4:0];
                if (wr_field[3]) lat.day[7:0]    <= dat_to_target;
                if (wr_field[4]) begin
                    lat.day[8]    <= dat_to_target[0];
                    lat.halt      <= dat_to_target[6];
                    lat.day_carry <= dat_to_target[7];
                end
            end
        end
    end

    always_comb begin
        rd_val = 8'hFF;
        case (addr)
            RtcLatch: rd_val = {7'b0, arm};
            RtcSec:   rd_val = {2'b0, lat.sec};
            RtcMin:   rd_val = {2'b0, lat.min};
            RtcHour:  rd_val = {3'b0, lat.hour};
            RtcDayLo: rd_val = lat.day[7:0];
            RtcDayHi: rd_val = {lat.day_carry, lat.halt, 5'b0, lat.day[8]};
            default:  rd_val = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack              <= 1'b0;
            dat_to_initiator <= 8'hFF;
        end else begin
            ack <= req;
            if (req) dat_to_initiator <= rd_val;
        end
    end

endmodule

// File: tb/tb_gbc_mbc3_rtc.sv
// Self-checking bench for gbc_mbc3_rtc at CLK_HZ=4; the restore test runs only
// when GBC_RTC_SAVE_EN is defined.
module tb_gbc_mbc3_rtc;
    import gbc_rtc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] addr = '0;
    logic [7:0] wdat = '0;
    logic [7:0] rdat;
    logic       we = 1'b0;
    logic       cyc = 1'b0;
    logic       stb = 1'b0;
    logic       ack;
    logic       stall;
`ifdef GBC_RTC_SAVE_EN
    logic [47:0] save_image;
    logic [47:0] restore_image = '0;
    logic        restore_strobe = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Entry: {check_data, addr, expected data}
    logic [12:0] exp_q[$];
    logic [12:0] mon_e;
    logic        acc_pending;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    gbc_mbc3_rtc #(.CLK_HZ(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr),
        .dat_to_target   (wdat),
        .dat_to_initiator(rdat),
        .we              (we),
        .cyc             (cyc),
        .stb             (stb),
        .ack             (ack),
        .stall           (stall)
`ifdef GBC_RTC_SAVE_EN
        ,
        .save_image      (save_image),
        .restore_image   (restore_image),
        .restore_strobe  (restore_strobe)
`endif
    );

    always @(posedge clk or posedge rst) begin
        if (rst) acc_pending <= 1'b0;
        else     acc_pending <= cyc && stb;
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (ack !== acc_pending) begin
                errors++;
                $display("FAIL ack_timing t=%0t got %b want %b", $time, ack, acc_pending);
            end
            if (acc_pending) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty t=%0t got ack want no response", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e[12]) begin
                        checks++;
                        if (rdat !== mon_e[7:0]) begin
                            errors++;
                            $display("FAIL read_%h t=%0t got %h want %h", mon_e[11:8], $time, rdat, mon_e[7:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic [7:0] e);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; wdat = 8'h00;
        exp_q.push_back({1'b1, a, e});
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdat = d;
        exp_q.push_back({1'b0, a, 8'h00});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
        end
    endtask

    task automatic latch();
        bus_wr(4'h0, 8'h00);
        bus_wr(4'h0, 8'h01);
    endtask

    // Halts first so no tick lands mid-setup; the final DH write releases halt.
    task automatic set_time(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                            input logic [7:0] dl, input logic [7:0] dh);
        bus_wr(4'hC, 8'h40);
        bus_wr(4'hB, dl);
        bus_wr(4'hA, h);
        bus_wr(4'h9, m);
        bus_wr(4'h8, s);
        bus_wr(4'hC, dh);
    endtask

    task automatic read_all(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                            input logic [7:0] dl, input logic [7:0] dh);
        bus_rd(4'h8, s);
        bus_rd(4'h9, m);
        bus_rd(4'hA, h);
        bus_rd(4'hB, dl);
        bus_rd(4'hC, dh);
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'h8, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 4'h9, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 4'hA, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 4'hB, 8'h00, 8'h00};
        vecs[4] = '{1'b0, 4'hC, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 4'hD, 8'h00, 8'hFF};
        vecs[6] = '{1'b0, 4'h0, 8'h00, 8'h00};
        vecs[7] = '{1'b1, 4'h3, 8'h55, 8'h00};
        vecs[8] = '{1'b0, 4'h3, 8'h00, 8'hFF};
        vecs[9] = '{1'b0, 4'hF, 8'h00, 8'hFF};

        repeat (3) @(negedge clk);
        check("reset_ack", 48'(ack), 48'h0);
        check("reset_dat", 48'(rdat), 48'hFF);
        check("reset_stall", 48'(stall), 48'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) bus_wr(vecs[i].addr, vecs[i].data);
            else            bus_rd(vecs[i].addr, vecs[i].exp);
        end

        // Full cascade: 511d 23:59:59 rolls to zero and sets the day carry.
        set_time(8'd59, 8'd59, 8'd23, 8'hFF, 8'h01);
        idle(4);
        latch();
        read_all(8'h00, 8'h00, 8'h00, 8'h00, 8'h80);

        // Hour 31 wraps silently; day stays put.
        set_time(8'd59, 8'd59, 8'd31, 8'h03, 8'h00);
        idle(4);
        latch();
        read_all(8'h00, 8'h00, 8'h00, 8'h03, 8'h00);

        // Out-of-range seconds: 62 -> 63 -> 0, no carry into minutes.
        set_time(8'd62, 8'd10, 8'd5, 8'h00, 8'h00);
        idle(8);
        latch();
        read_all(8'h00, 8'h0A, 8'h05, 8'h00, 8'h00);

        // Halted clock does not move; releasing halt gives one tick after 4 cycles.
        set_time(8'd5, 8'd10, 8'd5, 8'h00, 8'h40);
        idle(100);
        latch();
        bus_rd(4'h8, 8'h05);
        bus_rd(4'hC, 8'h40);
        bus_wr(4'hC, 8'h00);
        idle(4);
        latch();
        bus_rd(4'h8, 8'h06);
        bus_rd(4'hC, 8'h00);

        // Latch arm: 1 then 1 does not copy; 0 then 1 does.
        set_time(8'd20, 8'd0, 8'd0, 8'h00, 8'h00);
        latch();
        idle(4);
        bus_wr(4'h0, 8'h01);
        bus_rd(4'h8, 8'd20);
        bus_rd(4'h0, 8'h01);
        latch();
        bus_rd(4'h8, 8'd22);

        // Minute write on a tick that would carry into minutes.
        set_time(8'd59, 8'd7, 8'd0, 8'h00, 8'h00);
        idle(3);
        bus_wr(4'h9, 8'd20);
        latch();
        read_all(8'h00, 8'h14, 8'h00, 8'h00, 8'h00);

        // Latch on the tick cycle captures the pre-tick seconds.
        set_time(8'd30, 8'd0, 8'd0, 8'h00, 8'h00);
        idle(2);
        latch();
        bus_rd(4'h8, 8'h1E);

`ifdef GBC_RTC_SAVE_EN
        set_time(8'd0, 8'd0, 8'd0, 8'h00, 8'h40);
        restore_image = 48'h0000_0400_000A;
        bus_wr(4'h8, 8'd5);
        restore_strobe = 1'b1;
        @(negedge clk);
        restore_strobe = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("save_image", save_image, 48'h0000_0400_000A);
        latch();
        bus_rd(4'h8, 8'd10);
        bus_rd(4'hC, 8'h40);
`endif

        // Reset during the ack cycle drops ack at once and clears the state.
        bus_rd(4'h8, 8'h1E);
        @(posedge clk);
        #2;
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        #1;
        check("mid_reset_ack", 48'(ack), 48'h0);
        check("mid_reset_dat", 48'(rdat), 48'hFF);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        bus_rd(4'h8, 8'h00);
        bus_rd(4'h0, 8'h00);
        idle(2);
        check("queue_drained", 48'(exp_q.size()), 48'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
